multi_duck_game_logic: RTL and testbench

MULTI_DUCK_GAME_LOGIC -- requirements
Module: multi_duck_game_logic

---
 rtl/duck_game_pkg.sv | 17 +
 rtl/multi_duck_game_logic_if.sv | 35 +++
 rtl/duck_hit_detect.sv | 48 ++++
 rtl/multi_duck_game_logic.sv | 152 +++++++++++++++
 tb/tb_multi_duck_game_logic.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/duck_game_pkg.sv
// Shared types and default timing for the multi-duck shooting game.
package duck_game_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StCountdown,
    StHunting,
    StReload,
    StDeath,
    StGameOver
  } game_state_e;

  localparam int unsigned COUNTDOWN_CYC_DEF = 7500 * 65000;
  localparam int unsigned DEATH_CYC_DEF     = 4500 * 65000;
  localparam int unsigned DOG_CYC_DEF       = 2500 * 65000;

endpackage

// File: rtl/multi_duck_game_logic_if.sv
// Player inputs, duck positions and game status outputs of the duck game core.
interface multi_duck_game_logic_if #(
  parameter int unsigned N_DUCKS = 2
) ();
  logic                    game_enable;
  logic [11:0]             mouse_xpos;
  logic [11:0]             mouse_ypos;
  logic                    left_mouse;
  logic                    right_mouse;
  logic [12*N_DUCKS-1:0]   duck_xpos;
  logic [12*N_DUCKS-1:0]   duck_ypos;
  logic [N_DUCKS-1:0]      duck_active;
  logic [2:0]              bullets_in_magazine;
  logic [6:0]              bullets_left;
  logic [6:0]              my_score;
  logic                    hunt_start;
  logic                    show_reload_char;
  logic [N_DUCKS-1:0]      duck_killed;
  logic                    dog_bird_enable;
  logic                    game_over;

  modport master (
    output game_enable, mouse_xpos, mouse_ypos, left_mouse, right_mouse,
    output duck_xpos, duck_ypos, duck_active,
    input  bullets_in_magazine, bullets_left, my_score, hunt_start,
    input  show_reload_char, duck_killed, dog_bird_enable, game_over
  );

  modport slave (
    input  game_enable, mouse_xpos, mouse_ypos, left_mouse, right_mouse,
    input  duck_xpos, duck_ypos, duck_active,
    output bullets_in_magazine, bullets_left, my_score, hunt_start,
    output show_reload_char, duck_killed, dog_bird_enable, game_over
  );
endinterface

// File: rtl/duck_hit_detect.sv
// Combinational per-duck hit-box test; the lowest-indexed hit duck wins.
module duck_hit_detect #(
  parameter int unsigned N_DUCKS = 2,
  parameter int unsigned DUCK_W  = 96,
  parameter int unsigned DUCK_H  = 60
) (
  input  logic [11:0]           mouse_x_i,
  input  logic [11:0]           mouse_y_i,
  input  logic [12*N_DUCKS-1:0] duck_x_i,
  input  logic [12*N_DUCKS-1:0] duck_y_i,
  input  logic [N_DUCKS-1:0]    duck_active_i,
  output logic [N_DUCKS-1:0]    hit_onehot_o,
  output logic                  hit_any_o
);

  logic [N_DUCKS-1:0] in_box;
  logic [12:0]        mx;
  logic [12:0]        my;

  assign mx = {1'b0, mouse_x_i};
  assign my = {1'b0, mouse_y_i};

  // 13-bit bounds so corner + size can never wrap.
  for (genvar i = 0; i < N_DUCKS; i++) begin : g_box
    logic [12:0] x_lo;
    logic [12:0] y_lo;
    assign x_lo = {1'b0, duck_x_i[12*i +: 12]};
    assign y_lo = {1'b0, duck_y_i[12*i +: 12]};
    assign in_box[i] = duck_active_i[i] &&
                       (mx >= x_lo) && (mx <= x_lo + 13'(DUCK_W)) &&
                       (my >= y_lo) && (my <= y_lo + 13'(DUCK_H));
  end

  always_comb begin
    logic found;
    found        = 1'b0;
    hit_onehot_o = '0;
    for (int i = 0; i < N_DUCKS; i++) begin
      if (in_box[i] && !found) begin
        hit_onehot_o[i] = 1'b1;
        found           = 1'b1;
      end
    end
  end

  assign hit_any_o = |in_box;

endmodule

// File: rtl/multi_duck_game_logic.sv
// Game controller: ammunition, scoring, reload and duck-fall sequencing.
module multi_duck_game_logic
  import duck_game_pkg::*;
#(
  parameter int unsigned N_DUCKS       = 2,
  parameter int unsigned MAG_SIZE      = 3,
  parameter int unsigned AMMO_TOTAL    = 15,
  parameter int unsigned DUCK_W        = 96,
  parameter int unsigned DUCK_H        = 60,
  parameter int unsigned COUNTDOWN_CYC = COUNTDOWN_CYC_DEF,
  parameter int unsigned DEATH_CYC     = DEATH_CYC_DEF,
  parameter int unsigned DOG_CYC       = DOG_CYC_DEF
) (
  input logic                    clk,
  input logic                    rst,
  multi_duck_game_logic_if.slave bus
);

  localparam logic [2:0] MagFull = 3'(MAG_SIZE);
  localparam logic [6:0] ResInit = 7'(AMMO_TOTAL - MAG_SIZE);

  game_state_e        state_q, ret_q;
  logic [31:0]        cnt_q;
  logic [2:0]         mag_q;
  logic [6:0]         res_q, score_q;
  logic               hunt_q, show_q, dog_q, over_q;
  logic [N_DUCKS-1:0] killed_q;
  logic               left_q, right_q;

  logic               left_edge, right_edge, can_reload, hit_any;
  logic [6:0]         need, xfer;
  logic [N_DUCKS-1:0] hit_onehot;

  duck_hit_detect #(
    .N_DUCKS(N_DUCKS),
    .DUCK_W (DUCK_W),
    .DUCK_H (DUCK_H)
  ) u_hit (
    .mouse_x_i    (bus.mouse_xpos),
    .mouse_y_i    (bus.mouse_ypos),
    .duck_x_i     (bus.duck_xpos),
    .duck_y_i     (bus.duck_ypos),
    .duck_active_i(bus.duck_active),
    .hit_onehot_o (hit_onehot),
    .hit_any_o    (hit_any)
  );

  always_comb begin
    left_edge  = bus.left_mouse & ~left_q;
    right_edge = bus.right_mouse & ~right_q;
    can_reload = (mag_q != MagFull) && (res_q != 7'd0);
    need       = {4'd0, MagFull - mag_q};
    xfer       = (need < res_q) ? need : res_q;
  end

  always_ff @(posedge clk) begin
    left_q  <= bus.left_mouse;
    right_q <= bus.right_mouse;
    dog_q   <= 1'b0;
    if (rst) begin
      state_q  <= StIdle;
      ret_q    <= StHunting;
      cnt_q    <= COUNTDOWN_CYC;
      mag_q    <= MagFull;
      res_q    <= ResInit;
      score_q  <= 7'd0;
      hunt_q   <= 1'b0;
      show_q   <= 1'b0;
      over_q   <= 1'b0;
      killed_q <= '0;
      left_q   <= 1'b0;
      right_q  <= 1'b0;
    end else if (!bus.game_enable || state_q == StIdle) begin
      // Idle keeps the game freshly loaded; enable starts the countdown.
      state_q  <= bus.game_enable ? StCountdown : StIdle;
      cnt_q    <= COUNTDOWN_CYC;
      mag_q    <= MagFull;
      res_q    <= ResInit;
      score_q  <= 7'd0;
      hunt_q   <= 1'b0;
      show_q   <= 1'b0;
      over_q   <= 1'b0;
      killed_q <= '0;
    end else begin
      unique case (state_q)
        StCountdown, StHunting: begin
          if (state_q == StHunting && mag_q == 3'd0 && res_q == 7'd0) begin
            state_q <= StGameOver;
            hunt_q  <= 1'b0;
            over_q  <= 1'b1;
          end else if (right_edge) begin
            // A right edge always swallows a simultaneous shot.
            if (can_reload) begin
              state_q <= StReload;
              ret_q   <= state_q;
              mag_q   <= mag_q + xfer[2:0];
              res_q   <= res_q - xfer;
              show_q  <= 1'b0;
              hunt_q  <= 1'b1;
            end
          end else if (state_q == StCountdown) begin
            if (cnt_q == 32'd0) begin
              state_q <= StHunting;
              hunt_q  <= 1'b1;
            end else begin
              cnt_q <= cnt_q - 32'd1;
            end
          end else if (left_edge && mag_q != 3'd0) begin
            mag_q  <= mag_q - 3'd1;
            show_q <= (mag_q == 3'd1);
            if (hit_any) begin
              if (score_q != 7'd127) score_q <= score_q + 7'd1;
              killed_q <= hit_onehot;
              cnt_q    <= DEATH_CYC;
              state_q  <= StDeath;
              hunt_q   <= 1'b0;
              if (DEATH_CYC == DOG_CYC) dog_q <= 1'b1;
            end
          end
        end
        StReload: begin
          state_q <= ret_q;
          hunt_q  <= 1'b1;
        end
        StDeath: begin
          if (cnt_q == 32'd0) begin
            state_q  <= StHunting;
            killed_q <= '0;
            hunt_q   <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 32'd1;
            if (cnt_q - 32'd1 == DOG_CYC) dog_q <= 1'b1;
          end
        end
        StGameOver: begin
          over_q <= 1'b1;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.bullets_in_magazine = mag_q;
  assign bus.bullets_left        = res_q;
  assign bus.my_score            = score_q;
  assign bus.hunt_start          = hunt_q;
  assign bus.show_reload_char    = show_q;
  assign bus.duck_killed         = killed_q;
  assign bus.dog_bird_enable     = dog_q;
  assign bus.game_over           = over_q;

endmodule

// File: tb/tb_multi_duck_game_logic.sv
// Directed bench for multi_duck_game_logic with shortened timing constants.
module tb_multi_duck_game_logic;
  import duck_game_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   passed = 0;
  int   total  = 0;

  multi_duck_game_logic_if #(.N_DUCKS(2)) bus ();

  multi_duck_game_logic #(
    .N_DUCKS      (2),
    .MAG_SIZE     (3),
    .AMMO_TOTAL   (15),
    .DUCK_W       (96),
    .DUCK_H       (60),
    .COUNTDOWN_CYC(40),
    .DEATH_CYC    (20),
    .DOG_CYC      (10)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic shoot();
    bus.left_mouse = 1'b1;
    tick();
    bus.left_mouse = 1'b0;
    tick();
  endtask

  task automatic reload();
    bus.right_mouse = 1'b1;
    tick();
    bus.right_mouse = 1'b0;
    tick();
  endtask

  task automatic aim(input int x, input int y);
    bus.mouse_xpos = 12'(x);
    bus.mouse_ypos = 12'(y);
  endtask

  initial begin
    rst             = 1'b1;
    bus.game_enable = 1'b0;
    bus.left_mouse  = 1'b0;
    bus.right_mouse = 1'b0;
    bus.duck_xpos   = {12'd100, 12'd100};
    bus.duck_ypos   = {12'd100, 12'd100};
    bus.duck_active = 2'b00;
    aim(0, 0);
    tick(2);
    chk("rst_mag", 32'(bus.bullets_in_magazine), 3);
    chk("rst_res", 32'(bus.bullets_left), 12);
    chk("rst_score", 32'(bus.my_score), 0);
    chk("rst_hunt", 32'(bus.hunt_start), 0);
    chk("rst_killed", 32'(bus.duck_killed), 0);
    chk("rst_over", 32'(bus.game_over), 0);
    chk("rst_state", 32'(dut.state_q), 32'(StIdle));
    rst = 1'b0;

    // Countdown: 1 edge to enter, 41 edges in COUNTDOWN.
    bus.game_enable = 1'b1;
    tick();
    tick(40);
    chk("cd_not_yet", 32'(bus.hunt_start), 0);
    tick();
    chk("cd_hunt", 32'(bus.hunt_start), 1);

    shoot();
    chk("miss1_mag", 32'(bus.bullets_in_magazine), 2);
    shoot();
    chk("miss2_mag", 32'(bus.bullets_in_magazine), 1);
    chk("miss2_show", 32'(bus.show_reload_char), 0);
    shoot();
    chk("miss3_mag", 32'(bus.bullets_in_magazine), 0);
    chk("miss3_show", 32'(bus.show_reload_char), 1);
    reload();
    chk("rl1_mag", 32'(bus.bullets_in_magazine), 3);
    chk("rl1_res", 32'(bus.bullets_left), 9);
    chk("rl1_show", 32'(bus.show_reload_char), 0);

    // Both ducks overlap the cursor: duck 0 wins.
    bus.duck_active = 2'b11;
    aim(150, 130);
    bus.left_mouse = 1'b1;
    tick();
    bus.left_mouse = 1'b0;
    chk("hit_killed", 32'(bus.duck_killed), 1);
    chk("hit_score", 32'(bus.my_score), 1);
    chk("hit_mag", 32'(bus.bullets_in_magazine), 2);
    chk("hit_hunt", 32'(bus.hunt_start), 0);
    tick(9);
    chk("dog_early", 32'(bus.dog_bird_enable), 0);
    tick();
    chk("dog_pulse", 32'(bus.dog_bird_enable), 1);
    tick();
    chk("dog_end", 32'(bus.dog_bird_enable), 0);
    bus.right_mouse = 1'b1;
    tick();
    bus.right_mouse = 1'b0;
    chk("death_rl_mag", 32'(bus.bullets_in_magazine), 2);
    chk("death_rl_state", 32'(dut.state_q), 32'(StDeath));
    tick(8);
    chk("death_hold", 32'(bus.duck_killed), 1);
    chk("death_hunt0", 32'(bus.hunt_start), 0);
    tick();
    chk("death_exit_hunt", 32'(bus.hunt_start), 1);
    chk("death_exit_kill", 32'(bus.duck_killed), 0);

    // Inclusive right/bottom edge of the hit box.
    bus.duck_active = 2'b01;
    aim(196, 160);
    bus.left_mouse = 1'b1;
    tick();
    bus.left_mouse = 1'b0;
    chk("edge_hit_kill", 32'(bus.duck_killed), 1);
    chk("edge_hit_score", 32'(bus.my_score), 2);
    tick(21);
    chk("edge_hit_back", 32'(bus.hunt_start), 1);
    aim(197, 160);
    shoot();
    chk("edge_miss_kill", 32'(bus.duck_killed), 0);
    chk("edge_miss_score", 32'(bus.my_score), 2);
    chk("edge_miss_mag", 32'(bus.bullets_in_magazine), 0);

    bus.duck_active = 2'b00;
    reload();
    chk("rl2_res", 32'(bus.bullets_left), 6);
    bus.right_mouse = 1'b1;
    tick();
    bus.right_mouse = 1'b0;
    chk("full_rl_state", 32'(dut.state_q), 32'(StHunting));
    tick();
    chk("full_rl_res", 32'(bus.bullets_left), 6);
    shoot();
    reload();
    chk("rl3_mag", 32'(bus.bullets_in_magazine), 3);
    chk("rl3_res", 32'(bus.bullets_left), 5);
    shoot();
    shoot();
    shoot();
    reload();
    chk("rl4_res", 32'(bus.bullets_left), 2);
    shoot();
    // Simultaneous edges: reload only, no shot.
    bus.left_mouse  = 1'b1;
    bus.right_mouse = 1'b1;
    tick();
    bus.left_mouse  = 1'b0;
    bus.right_mouse = 1'b0;
    tick();
    chk("both_mag", 32'(bus.bullets_in_magazine), 3);
    chk("both_res", 32'(bus.bullets_left), 1);
    shoot();
    shoot();
    chk("pre_mag", 32'(bus.bullets_in_magazine), 1);
    reload();
    chk("part_mag", 32'(bus.bullets_in_magazine), 2);
    chk("part_res", 32'(bus.bullets_left), 0);
    reload();
    chk("empty_rl_mag", 32'(bus.bullets_in_magazine), 2);
    chk("empty_rl_state", 32'(dut.state_q), 32'(StHunting));
    shoot();
    shoot();
    chk("go_over", 32'(bus.game_over), 1);
    chk("go_hunt", 32'(bus.hunt_start), 0);

    bus.game_enable = 1'b0;
    tick();
    chk("idle_state", 32'(dut.state_q), 32'(StIdle));
    chk("idle_mag", 32'(bus.bullets_in_magazine), 3);
    chk("idle_res", 32'(bus.bullets_left), 12);
    chk("idle_over", 32'(bus.game_over), 0);
    chk("idle_score", 32'(bus.my_score), 0);

    // Reset during a fall.
    bus.game_enable = 1'b1;
    tick();
    tick(41);
    chk("re_hunt", 32'(bus.hunt_start), 1);
    bus.duck_active = 2'b01;
    aim(150, 130);
    bus.left_mouse = 1'b1;
    tick();
    bus.left_mouse = 1'b0;
    chk("re_kill", 32'(bus.duck_killed), 1);
    tick(4);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_kill", 32'(bus.duck_killed), 0);
    chk("midrst_state", 32'(dut.state_q), 32'(StIdle));
    chk("midrst_score", 32'(bus.my_score), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
